swap_pipe: RTL and testbench
============================

// Module: swap_pipe
//
// PURPOSE
// Registered, handshaked lane permuter. It is the pipelined successor to the two-input
// combinational swap, generalised to LANES lanes of WIDTH bits with four permutation modes.
// Sits between the register-read stage and the datapath as a one-stage valid/ready
// element. Each accepted beat is permuted and presented one cycle later.
//
// PARAMETERS
// WIDTH   32  bits per lane
// LANES   4   lane count; power of two, >= 2. Lane k = data[k*WIDTH +: WIDTH]
// CNT_W   16  width of the transfer counter
//
// PORTS
// clk        in   1             rising-edge clock
// reset_n    in   1             asynchronous, active-low reset
// in_valid   in   1             input beat valid
// in_ready   out  1             input beat accepted when in_valid & in_ready
// in_data    in   LANES*WIDTH   input lanes
// mode       in   2             00 pass, 01 pair swap, 10 reverse, 11 rotate; sampled with beat
// rot        in   $clog2(LANES) rotate amount, used only when mode==11; sampled with beat
// out_valid  out  1             output beat valid
// out_ready  in   1             downstream accepts when out_valid & out_ready
// out_data   out  LANES*WIDTH   permuted lanes
// xfer_cnt   out  CNT_W         count of completed output transfers
//
// BEHAVIOUR
// - Reset (async assert, sync-safe release): out_valid=0, out_data=0, xfer_cnt=0, skid empty.
//   in_ready is 1 as soon as reset_n=1. Reset mid-operation drops all held beats.
// - Permutation, out lane i from in lane j:
//   - 00: j = i.
//   - 01: j = i ^ 1; lanes 2k and 2k+1 exchange.
//   - 10: j = LANES-1-i.
//   - 11: j = (i + rot) mod LANES; the index wraps modulo LANES, with no lane loss.
// - Permute is combinational on in_data/mode/rot. The result is captured into the output
//   register on the accept cycle. Latency is 1 cycle from accept to out_valid.
// - Output register load: out_valid <= 1 and the data is loaded on accept when the output
//   register is empty or draining (out_ready=1).
// - Output register clear: out_valid <= 0 on a drain cycle with no accept.
// - Output hold: out_data and out_valid are held stable while out_valid=1 and out_ready=0.
// - Simultaneous accept and drain in the same cycle is full throughput:
//   one beat in, one beat out, with no bubble.
// - xfer_cnt increments by 1 on every out_valid & out_ready cycle and wraps 2^CNT_W-1 -> 0.
// - A change to mode or rot while a beat is held does not alter the held beat.
//
// CONFIGURATION
// SWAP_PIPE_SKID_EN defined: adds a one-entry skid register. in_ready becomes a register
// output, equal to !skid_valid, with no combinational path from out_ready.
// - A beat accepted while the output is stalled goes into the skid.
// - When the output drains, the skid moves to the output before any new beat.
// - Ordering is preserved, and capacity is 2 beats.
// - Latency is still 1 cycle when the skid is empty.
// SWAP_PIPE_SKID_EN undefined: no skid, capacity is 1 beat, and
// in_ready = !out_valid | out_ready (combinational).
//
// TESTING
// WIDTH=32, LANES=4; in_data lanes 0..3 = {0,1,2,3}.
// 1. Reset: reset_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, xfer_cnt=0
//    in the same cycle, without waiting for a clock edge.
// 2. Modes, out_ready=1, one beat each:
//    - 00 -> {0,1,2,3}
//    - 01 -> {1,0,3,2}
//    - 10 -> {3,2,1,0}
//    - 11 with rot=1 -> {1,2,3,0}
//    - 11 with rot=3 -> {3,0,1,2}
//    Each output appears 1 cycle after accept.
// 3. Streaming: 8 back-to-back beats with in_valid=1 and out_ready=1 -> 8 consecutive
//    out_valid cycles, in order, and xfer_cnt=8.
// 4. Backpressure: hold out_ready=0 for 3 cycles with a beat held -> out_data stable.
//    - Without the skid: in_ready=0.
//    - With SWAP_PIPE_SKID_EN: one extra beat accepted, then in_ready=0; after release
//      both beats come out in order.
// 5. Wrap: preload CNT_W=4 and perform 17 transfers -> xfer_cnt=1.
// 6. Mode change while stalled: mode 10 beat held, switch mode to 01 -> the held output
//    stays {3,2,1,0}.

Source files
------------

// File: rtl/swap_pipe.sv
// swap_pipe: registered valid/ready lane permuter (pass, pair swap, reverse, rotate).
// The beat is permuted combinationally and captured on accept, so a held beat
// never changes when mode/rot move afterwards.
// Optional build macro SWAP_PIPE_SKID_EN adds a one-entry skid buffer. With it,
// in_ready is a flop output and capacity is two beats.
module swap_pipe #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH-1:0]     in_data,
    input  logic [1:0]                 mode,
    input  logic [$clog2(LANES)-1:0]   rot,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*WIDTH-1:0]     out_data,
    output logic [CNT_W-1:0]           xfer_cnt
);
    localparam int LW = $clog2(LANES);
    localparam int DW = LANES * WIDTH;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [DW-1:0] perm;
    logic          accept;
    logic          drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid_q & out_ready;

    // Lane permutation. LANES is a power of two, so LANES-1-i is ~i and the
    // rotate index wraps for free in LW bits.
    always_comb begin
        logic [LW-1:0] dst;
        logic [LW-1:0] src;
        perm = '0;
        for (int i = 0; i < LANES; i++) begin
            dst = LW'(i);
            case (mode)
                2'b00:   src = dst;
                2'b01:   src = dst ^ LW'(1);
                2'b10:   src = ~dst;
                default: src = dst + rot;
            endcase
            perm[i*WIDTH +: WIDTH] = in_data[int'(src)*WIDTH +: WIDTH];
        end
    end

    // Completed output transfer counter, wraps naturally at 2^CNT_W.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (drain) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end

`ifdef SWAP_PIPE_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;

    assign in_ready = !skid_valid_q;

    // Output/skid load: a parked skid beat always goes out before any new beat.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = perm;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm;
        end
    end

    // Skid register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = !out_valid_q | out_ready;

    // Output load on accept, clear on drain without accept, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = perm;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Output register and transfer counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_swap_pipe.sv
// Bench for swap_pipe (WIDTH=32, LANES=4, CNT_W=4). It runs with or without
// SWAP_PIPE_SKID_EN. Expected beats are queued on accept and compared on drain.
module tb_swap_pipe;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   mode;
    logic [1:0]   rot;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   xfer_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    logic [127:0] exp_cur;
    logic [127:0] sb[$];

    swap_pipe #(.WIDTH(32), .LANES(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .rot(rot), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mk(logic [31:0] a0, logic [31:0] a1,
                                        logic [31:0] a2, logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] model(logic [127:0] d, logic [1:0] m, logic [1:0] r);
        logic [31:0] a0, a1, a2, a3;
        a0 = d[31:0]; a1 = d[63:32]; a2 = d[95:64]; a3 = d[127:96];
        case (m)
            2'd0: return mk(a0, a1, a2, a3);
            2'd1: return mk(a1, a0, a3, a2);
            2'd2: return mk(a3, a2, a1, a0);
            default: case (r)
                2'd0: return mk(a0, a1, a2, a3);
                2'd1: return mk(a1, a2, a3, a0);
                2'd2: return mk(a2, a3, a0, a1);
                default: return mk(a3, a0, a1, a2);
            endcase
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Drive one beat and wait (bounded) for it to be accepted.
    task automatic send(input logic [127:0] d, input logic [1:0] m, input logic [1:0] r,
                        input logic [127:0] e);
        bit ok = 0;
        tick();
        in_data = d; mode = m; rot = r; exp_cur = e; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            tick();
        end
        if (!ok) chk("accept_timeout", 128'(ok), 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset;
        tick();
        reset_n = 1'b0;
        sb.delete();
        tick();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) chk("sb_unexpected_output", out_data, 128'd0);
                else chk("sb_data", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    typedef struct {
        logic [1:0]   m;
        logic [1:0]   r;
        logic [127:0] e;
    } vec_t;

    vec_t tbl[5];
    logic [127:0] base;
    int n_before;

    initial begin
        base = mk(0, 1, 2, 3);
        tbl[0] = '{2'd0, 2'd0, mk(0, 1, 2, 3)};
        tbl[1] = '{2'd1, 2'd0, mk(1, 0, 3, 2)};
        tbl[2] = '{2'd2, 2'd0, mk(3, 2, 1, 0)};
        tbl[3] = '{2'd3, 2'd1, mk(1, 2, 3, 0)};
        tbl[4] = '{2'd3, 2'd3, mk(3, 0, 1, 2)};

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; rot = '0;
        out_ready = 1'b1; exp_cur = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_xfer_cnt", 128'(xfer_cnt), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // Modes: one beat each, output one cycle after accept.
        foreach (tbl[i]) begin
            send(base, tbl[i].m, tbl[i].r, tbl[i].e);
            @(negedge clk);
            chk($sformatf("mode%0d_valid", i), 128'(out_valid), 128'd1);
            chk($sformatf("mode%0d_data", i), out_data, tbl[i].e);
        end
        tick();
        chk("modes_xfer_cnt", 128'(xfer_cnt), 128'd5);

        // Asynchronous reset while a beat is held.
        out_ready = 1'b0;
        send(base, 2'd2, 2'd0, mk(3, 2, 1, 0));
        chk("pre_reset_valid", 128'(out_valid), 128'd1);
        #3 reset_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'd0);
        chk("async_rst_data", out_data, 128'd0);
        chk("async_rst_cnt", 128'(xfer_cnt), 128'd0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;

        // Streaming: 8 back-to-back beats.
        n_before = n_out;
        for (int i = 0; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                in_data = mk(i*16, i*16+1, i*16+2, i*16+3);
                mode = 2'(i); rot = 2'(i / 4 + 1);
                exp_cur = model(in_data, mode, rot);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) chk($sformatf("stream_valid%0d", i), 128'(out_valid), 128'd1);
        end
        tick();
        @(negedge clk);
        chk("stream_count", 128'(n_out - n_before), 128'd8);
        chk("stream_xfer_cnt", 128'(xfer_cnt), 128'd8);
        chk("stream_drained", 128'(out_valid), 128'd0);

        // Backpressure with a mode change while the beat is held.
        out_ready = 1'b0;
        n_before = n_out;
        send(base, 2'd2, 2'd0, mk(3, 2, 1, 0));
        in_data = base; mode = 2'd1; rot = 2'd0; exp_cur = mk(1, 0, 3, 2);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_held_data", out_data, mk(3, 2, 1, 0));
`ifdef SWAP_PIPE_SKID_EN
            chk("bp_in_ready", 128'(in_ready), 128'(c == 0));
`else
            chk("bp_in_ready", 128'(in_ready), 128'd0);
`endif
            tick();
`ifdef SWAP_PIPE_SKID_EN
            if (c == 0) begin in_valid = 1'b0; mode = 2'd3; rot = 2'd1; end
`endif
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("bp_two_out", 128'(n_out - n_before), 128'd2);
        chk("bp_sb_empty", 128'(sb.size()), 128'd0);

        // Counter wrap with CNT_W=4: 17 transfers leave 1.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            logic [127:0] d;
            logic [1:0] m, r;
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 2'($urandom_range(0, 3)); r = 2'($urandom_range(0, 3));
            send(d, m, r, model(d, m, r));
        end
        repeat (2) tick();
        @(negedge clk);
        chk("wrap_xfer_cnt", 128'(xfer_cnt), 128'd1);
        chk("final_sb_empty", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
